gpreg_xfer_seq: RTL
===================

# gpreg_xfer_seq

Register-transfer sequencer that drives the control lines of a bank of `gpreg` general-purpose registers. It accepts one move or clear command at a time and generates the ordered per-register strobes. For a move it asserts the source onto the main bus, raises and then drops the destination `LOAD`, and releases the bus. The falling `LOAD` edge captures while the bus is still driven. It sits directly upstream of the register bank, between the instruction decoder and the `gpreg` control inputs.

## Interface
Parameters:
- `NREGS`, 4: number of registers controlled; legal range 2–8.
- `IDX_W`, 2: width of register index; must satisfy 2^IDX_W ≥ NREGS.
- `DELAY_RISE`, 0: rise delay on registered outputs, for simulation only.
- `DELAY_FALL`, 0: fall delay on registered outputs, for simulation only.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `REQ` input 1: command request, level-sampled in IDLE.
- `OP` input 1: 0 = move SRC→DST; 1 = clear DST.
- `SRC` input IDX_W: source register index; ignored for clear.
- `DST` input IDX_W: destination register index.
- `ACK` output 1: one-cycle pulse on the cycle after a command is accepted.
- `BUSY` output 1: high from acceptance until DONE, inclusive.
- `DONE` output 1: one-cycle pulse when the command completes.
- `ERR` output 1: one-cycle pulse when a command is rejected.
- `ASSERT_MAIN_bar` output NREGS: per-register main-bus enable, active-low.
- `LOAD` output NREGS: per-register load; capture happens on the falling edge.
- `CLEAR_bar` output NREGS: per-register synchronous clear, active-low.

## Operation
- All outputs are registered.
- Reset values:
  - `ASSERT_MAIN_bar`, `CLEAR_bar`: all ones.
  - `LOAD`: all zeros.
  - `ACK`, `BUSY`, `DONE`, `ERR`: 0.
  - State: IDLE.
- States: IDLE → DRIVE → LOAD_HI → LOAD_LO → FIN → IDLE.
- IDLE:
  - If `REQ` is high, latch `OP`, `SRC` and `DST`.
  - Accept the command when it is legal; reject it otherwise.
  - Accept: pulse `ACK` and go to DRIVE.
  - Reject: pulse `ERR`, stay in IDLE, leave the strobes untouched.
- Illegal commands:
  - `DST` ≥ NREGS.
  - Move with `SRC` ≥ NREGS.
  - Move with `SRC` == `DST`.
  - Clear when clear support is compiled out.
- DRIVE:
  - Move: `ASSERT_MAIN_bar[SRC]`=0 so the bus settles.
  - Clear: `CLEAR_bar[DST]`=0.
- LOAD_HI: `LOAD[DST]`=1; the DRIVE-state strobe is held.
- LOAD_LO:
  - `LOAD[DST]`=0; this falling edge is the capture point.
  - `ASSERT_MAIN_bar[SRC]` or `CLEAR_bar[DST]` is still held for hold time.
- FIN: release all strobes to inactive, pulse `DONE`, return to IDLE.
- At most one `ASSERT_MAIN_bar` bit is low at any time, and it is never low outside DRIVE..LOAD_LO.
- At most one `LOAD` bit is high at any time.
- `REQ` held high across FIN is re-sampled in the following IDLE cycle. That command is a new one; there is no queuing.
- Inputs other than `RESET` are ignored while not in IDLE.

## Timing
- Accept edge = cycle 0. Strobes change on the following edges:
  - Cycle 1: bus assert.
  - Cycle 2: `LOAD` rises.
  - Cycle 3: `LOAD` falls.
  - Cycle 4: release and `DONE`.
- `ACK` is visible in cycle 1. `BUSY` is high in cycles 1–4.
- Minimum spacing between accepted commands is 5 cycles.
- Bus drive precedes the `LOAD` rising edge by 1 cycle. It outlasts the `LOAD` falling edge by 1 cycle.
- `RESET` mid-command: the next edge forces every output to its reset value and the state to IDLE.
  - If `LOAD` was high, it falls on the same edge as the bus release. The destination capture is undefined.
  - Software must re-initialise registers after reset.
- `RESET` and `REQ` asserted together: `RESET` wins; no `ACK` and no `ERR`.

## Configuration
- Macro `GPREG_XFER_CLEAR_EN`.
- Defined: `OP`=1 performs the clear sequence above.
- Undefined:
  - `OP`=1 is illegal and produces `ERR`.
  - `CLEAR_bar` is constant all ones, and no clear logic is synthesised.

## Test plan
- Reset: assert `RESET` for 2 cycles → all outputs at reset values. Then `REQ`=1, `OP`=0, `SRC`=1, `DST`=2 → `ACK` in cycle 1 and `ASSERT_MAIN_bar`=4'b1101 in cycles 1–3. `LOAD`=4'b0100 in cycle 2 only; `DONE` in cycle 4 and all strobes inactive.
- Illegal commands, each → `ERR` pulse only, no strobe change, `BUSY`=0:
  - `SRC`=`DST`=3.
  - `DST`=4 with NREGS=4.
- Clear with macro defined: `OP`=1, `DST`=0 → `CLEAR_bar`=4'b1110 in cycles 1–3, `LOAD[0]` high in cycle 2 only, `DONE` in cycle 4.
- Clear with macro undefined: `OP`=1, `DST`=0 → `ERR` pulse, `CLEAR_bar` remains 4'b1111.
- `REQ` held high with alternating commands: 3→0, then 0→1 → second `ACK` exactly 5 cycles after the first. The assertions never overlap: no cycle has two `ASSERT_MAIN_bar` bits low.
- `RESET` in LOAD_HI of move 2→1 → next cycle `LOAD`=0, `ASSERT_MAIN_bar`=4'b1111, `BUSY`=0 and no `DONE`. A new `REQ` is accepted on the first edge after `RESET` drops.

Source files
------------

// File: rtl/gpreg_xfer_seq_if.sv
// gpreg_xfer_seq_if: command and strobe bundle between the instruction decoder
// (master), the transfer sequencer (slave) and the gpreg bank control inputs.
interface gpreg_xfer_seq_if #(
    parameter int NREGS = 4,
    parameter int IDX_W = 2
) ();
    logic             REQ;
    logic             OP;
    logic [IDX_W-1:0] SRC;
    logic [IDX_W-1:0] DST;
    logic             ACK;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [NREGS-1:0] ASSERT_MAIN_bar;
    logic [NREGS-1:0] LOAD;
    logic [NREGS-1:0] CLEAR_bar;

    modport master (
        output REQ, OP, SRC, DST,
        input  ACK, BUSY, DONE, ERR, ASSERT_MAIN_bar, LOAD, CLEAR_bar
    );

    modport slave (
        input  REQ, OP, SRC, DST,
        output ACK, BUSY, DONE, ERR, ASSERT_MAIN_bar, LOAD, CLEAR_bar
    );
endinterface

// File: rtl/gpreg_xfer_seq.sv
// gpreg_xfer_seq: sequences one move (SRC->DST over the main bus) or clear of a
// gpreg bank per command: bus/clear strobe, LOAD rise, LOAD fall (capture),
// release with DONE. All outputs are registered and reflect the state entered.
// Optional clear support is compiled in with `define GPREG_XFER_CLEAR_EN.
module gpreg_xfer_seq #(
    parameter int NREGS      = 4,
    parameter int IDX_W      = 2,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input logic              CLK,
    input logic              RESET,
    gpreg_xfer_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_dst;
    logic [IDX_W-1:0] w_src;
    logic [IDX_W-1:0] w_dst;
    logic             w_op;
    logic [NREGS-1:0] w_src_oh;
    logic [NREGS-1:0] w_dst_oh;

    logic             w_dst_ok;
    logic             w_src_ok;
    logic             w_legal;
    logic             w_strobe;

    logic             r_ack, r_busy, r_done, r_err;
    logic             w_ack, w_busy, w_done, w_err;
    logic [NREGS-1:0] r_amb, r_load;
    logic [NREGS-1:0] w_amb, w_load;

`ifdef GPREG_XFER_CLEAR_EN
    logic             r_op;
    logic [NREGS-1:0] r_clrb;
    logic [NREGS-1:0] w_clrb;
`endif

    // Delay parameters only annotate simulation timing; they shape no logic.
    logic w_unused_dly;
    assign w_unused_dly = (DELAY_RISE != 0) || (DELAY_FALL != 0);

    // Command fields: live inputs while IDLE (acceptance edge), latched copy after.
    always_comb begin
        w_src = (r_state == S_IDLE) ? bus.SRC : r_src;
        w_dst = (r_state == S_IDLE) ? bus.DST : r_dst;
`ifdef GPREG_XFER_CLEAR_EN
        w_op  = (r_state == S_IDLE) ? bus.OP : r_op;
`else
        w_op  = 1'b0;
`endif
        w_src_oh = NREGS'(1) << w_src;
        w_dst_oh = NREGS'(1) << w_dst;
    end

    // Legality of the command presented on the inputs.
    always_comb begin
        w_dst_ok = int'(bus.DST) < NREGS;
        w_src_ok = int'(bus.SRC) < NREGS;
`ifdef GPREG_XFER_CLEAR_EN
        w_legal  = w_dst_ok && (bus.OP || (w_src_ok && (bus.SRC != bus.DST)));
`else
        w_legal  = w_dst_ok && !bus.OP && w_src_ok && (bus.SRC != bus.DST);
`endif
    end

    // Next state plus next registered outputs, derived from the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.REQ) begin
                    if (w_legal) begin
                        w_state_nxt = S_DRIVE;
                        w_ack       = 1'b1;
                    end else begin
                        w_err       = 1'b1;
                    end
                end
            end
            S_DRIVE:   w_state_nxt = S_LOAD_HI;
            S_LOAD_HI: w_state_nxt = S_LOAD_LO;
            S_LOAD_LO: w_state_nxt = S_FIN;
            S_FIN:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        // Bus/clear strobe spans DRIVE..LOAD_LO so it brackets both LOAD edges.
        w_strobe = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_LOAD_HI) ||
                   (w_state_nxt == S_LOAD_LO);
        w_busy   = (w_state_nxt != S_IDLE);
        w_done   = (w_state_nxt == S_FIN);
        w_load   = (w_state_nxt == S_LOAD_HI) ? w_dst_oh : '0;
        w_amb    = (w_strobe && !w_op) ? ~w_src_oh : '1;
`ifdef GPREG_XFER_CLEAR_EN
        w_clrb   = (w_strobe && w_op) ? ~w_dst_oh : '1;
`endif
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Output registers and command latch (latched on any REQ seen in IDLE).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_amb  <= '1;
            r_load <= '0;
            r_src  <= '0;
            r_dst  <= '0;
`ifdef GPREG_XFER_CLEAR_EN
            r_op   <= 1'b0;
            r_clrb <= '1;
`endif
        end else begin
            r_ack  <= w_ack;
            r_busy <= w_busy;
            r_done <= w_done;
            r_err  <= w_err;
            r_amb  <= w_amb;
            r_load <= w_load;
`ifdef GPREG_XFER_CLEAR_EN
            r_clrb <= w_clrb;
`endif
            if ((r_state == S_IDLE) && bus.REQ) begin
                r_src <= bus.SRC;
                r_dst <= bus.DST;
`ifdef GPREG_XFER_CLEAR_EN
                r_op  <= bus.OP;
`endif
            end
        end
    end

    assign bus.ACK             = r_ack;
    assign bus.BUSY            = r_busy;
    assign bus.DONE            = r_done;
    assign bus.ERR             = r_err;
    assign bus.ASSERT_MAIN_bar = r_amb;
    assign bus.LOAD            = r_load;
`ifdef GPREG_XFER_CLEAR_EN
    assign bus.CLEAR_bar       = r_clrb;
`else
    assign bus.CLEAR_bar       = '1;
`endif
endmodule
